conta_univ_param: RTL and testbench

//  Parametrised universal counter. It generalises the fixed up, down, up/down,
//  mod-5 and variable-modulus counters into one block of WIDTH bits.
//  - Runtime modulus M, direction and wrap/saturate mode.
//  - Synchronous parallel load.
//  - Terminal-count and wrap-event outputs for cascading and timing in the digital-systems labs.

---
 rtl/conta_univ_param.sv | 91 +++++++++
 tb/tb_conta_univ_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/conta_univ_param.sv
`timescale 1ns/1ps
// conta_univ_param
//   Parametrised universal counter: runtime modulus, up/down direction,
//   wrap or saturate at the terminal value, synchronous parallel load.
//   Provides a combinational terminal-count for cascading and a registered
//   one-cycle wrap pulse.
// Ports
//   clk      rising-edge clock
//   reset    asynchronous reset, active-low
//   enable   1 = count this cycle, 0 = hold
//   up_down  1 = up, 0 = down
//   M        modulus (counts 0..M-1); 0 selects the full 2^WIDTH range
//   load     synchronous load of d (wins over enable)
//   d        load value, clamped to the top value
//   sat      0 = wrap at terminal, 1 = saturate at terminal
//   q        registered count
//   tc       combinational terminal count, forced low during reset
//   wrap     registered pulse, high for the cycle after a wrap edge
module conta_univ_param #(
    parameter int unsigned      WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic [WIDTH-1:0] M,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             sat,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             at_term;

    // M=0 wraps naturally to all-ones, giving the full range.
    always_comb top = M - ONE;

    always_comb at_term = up_down ? (q >= top) : (q == '0);
    always_comb tc      = reset & enable & at_term;

    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        if (load) begin
            q_nxt = (d > top) ? top : d;
        end else if (enable) begin
            if (up_down) begin
                if (q < top) begin
                    q_nxt = q + ONE;
                end else if (!sat) begin
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    // Also pulls an out-of-range q (after M shrank) back to top.
                    q_nxt = top;
                end
            end else begin
                if (q > top) begin
                    // M shrank below q: clamp without signalling a wrap.
                    q_nxt = top;
                end else if (q != '0) begin
                    q_nxt = q - ONE;
                end else if (!sat) begin
                    q_nxt    = top;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q    <= RESET_VAL;
            wrap <= 1'b0;
        end else begin
            q    <= q_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_conta_univ_param.sv
`timescale 1ns/1ps
module tb_conta_univ_param;

    typedef struct {
        logic [2:0] q;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, enable, up_down, load, sat;
    logic [2:0] M, d;
    logic [2:0] q;
    logic       tc, wrap;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #1 clk = ~clk;

    conta_univ_param #(.WIDTH(3), .RESET_VAL(3'd0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .M(M), .load(load), .d(d), .sat(sat),
        .q(q), .tc(tc), .wrap(wrap)
    );

    // Apply inputs on the falling edge, away from the sampling edge.
    task automatic drv(input logic ld, input logic [2:0] dv, input logic en,
                       input logic ud, input logic [2:0] m, input logic s);
        @(negedge clk);
        load = ld; d = dv; enable = en; up_down = ud; M = m; sat = s;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b0; enable = 1'b1; up_down = 1'b0; M = 3'd5;
        load = 1'b0; d = 3'd0; sat = 1'b0;
        #0.5;
        checks++; if (q !== 3'd0)   begin failures++; $display("FAIL reset_q got=%0d exp=0", q); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%0b exp=0", wrap); end
        checks++; if (tc !== 1'b0)   begin failures++; $display("FAIL reset_tc got=%0b exp=0", tc); end
        #2.5;
        @(posedge clk); #0.5;
        e = '{q: 3'd0, wrap: 1'b0};
        checks++; if (q !== e.q) begin failures++; $display("FAIL reset_hold_q got=%0d exp=%0d", q, e.q); end
    endtask

    task automatic test_count_up();
        int   etc[6] = '{0, 0, 0, 0, 1, 0};
        int   eq[6]  = '{1, 2, 3, 4, 0, 1};
        int   ew[6]  = '{0, 0, 0, 0, 1, 0};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            drv(1'b0, 3'd0, 1'b1, 1'b1, 3'd5, 1'b0);
            reset = 1'b1;
            sb.push_back('{q: 3'(eq[i]), wrap: 1'(ew[i])});
            #0.5;
            checks++; if (tc !== 1'(etc[i])) begin failures++; $display("FAIL up_tc step%0d got=%0b exp=%0d", i, tc, etc[i]); end
            @(posedge clk); #0.5;
            e = sb.pop_front();
            checks++; if (q !== e.q)       begin failures++; $display("FAIL up_q step%0d got=%0d exp=%0d", i, q, e.q); end
            checks++; if (wrap !== e.wrap) begin failures++; $display("FAIL up_wrap step%0d got=%0b exp=%0b", i, wrap, e.wrap); end
        end
    endtask

    task automatic test_load_down_sat();
        int   etc[5] = '{0, 0, 0, 1, 1};
        int   eq[5]  = '{2, 1, 0, 0, 0};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drv(1'b1, 3'd2, 1'b0, 1'b0, 3'd5, 1'b1);
            else        drv(1'b0, 3'd0, 1'b1, 1'b0, 3'd5, 1'b1);
            sb.push_back('{q: 3'(eq[i]), wrap: 1'b0});
            #0.5;
            checks++; if (tc !== 1'(etc[i])) begin failures++; $display("FAIL down_tc step%0d got=%0b exp=%0d", i, tc, etc[i]); end
            @(posedge clk); #0.5;
            e = sb.pop_front();
            checks++; if (q !== e.q)       begin failures++; $display("FAIL down_q step%0d got=%0d exp=%0d", i, q, e.q); end
            checks++; if (wrap !== e.wrap) begin failures++; $display("FAIL down_wrap step%0d got=%0b exp=%0b", i, wrap, e.wrap); end
        end
    endtask

    task automatic test_full_range();
        int   eq[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            drv(1'b0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b0);
            sb.push_back('{q: 3'(eq[i]), wrap: (i == 7)});
            #0.5;
            checks++; if (tc !== (i == 7)) begin failures++; $display("FAIL full_tc step%0d got=%0b exp=%0b", i, tc, (i == 7)); end
            @(posedge clk); #0.5;
            e = sb.pop_front();
            checks++; if (q !== e.q)       begin failures++; $display("FAIL full_q step%0d got=%0d exp=%0d", i, q, e.q); end
            checks++; if (wrap !== e.wrap) begin failures++; $display("FAIL full_wrap step%0d got=%0b exp=%0b", i, wrap, e.wrap); end
        end
    endtask

    task automatic test_load_clamp();
        int   etc[2] = '{0, 1};
        int   eq[2]  = '{3, 0};
        int   ew[2]  = '{0, 1};
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drv((i == 0), 3'd6, 1'b1, 1'b1, 3'd4, 1'b0);
            sb.push_back('{q: 3'(eq[i]), wrap: 1'(ew[i])});
            #0.5;
            checks++; if (tc !== 1'(etc[i])) begin failures++; $display("FAIL clamp_tc step%0d got=%0b exp=%0d", i, tc, etc[i]); end
            @(posedge clk); #0.5;
            e = sb.pop_front();
            checks++; if (q !== e.q)       begin failures++; $display("FAIL clamp_q step%0d got=%0d exp=%0d", i, q, e.q); end
            checks++; if (wrap !== e.wrap) begin failures++; $display("FAIL clamp_wrap step%0d got=%0b exp=%0b", i, wrap, e.wrap); end
        end
    endtask

    // Shrink M from 7 to 3 while q=5, once counting up and once down.
    task automatic test_shrink_m();
        int   ld[4]  = '{1, 0, 1, 0};
        int   ud[4]  = '{1, 1, 0, 0};
        int   mm[4]  = '{7, 3, 7, 3};
        int   etc[4] = '{0, 1, 0, 0};
        int   eq[4]  = '{5, 0, 5, 2};
        int   ew[4]  = '{0, 1, 0, 0};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drv(1'(ld[i]), 3'd5, ~1'(ld[i]), 1'(ud[i]), 3'(mm[i]), 1'b0);
            sb.push_back('{q: 3'(eq[i]), wrap: 1'(ew[i])});
            #0.5;
            checks++; if (tc !== 1'(etc[i])) begin failures++; $display("FAIL shrink_tc step%0d got=%0b exp=%0d", i, tc, etc[i]); end
            @(posedge clk); #0.5;
            e = sb.pop_front();
            checks++; if (q !== e.q)       begin failures++; $display("FAIL shrink_q step%0d got=%0d exp=%0d", i, q, e.q); end
            checks++; if (wrap !== e.wrap) begin failures++; $display("FAIL shrink_wrap step%0d got=%0b exp=%0b", i, wrap, e.wrap); end
        end
    endtask

    // q=2 with M=3: saturate up, hold, then saturate down to 0.
    task automatic test_sat_hold();
        int   en[5]  = '{1, 0, 1, 1, 1};
        int   ud[5]  = '{1, 1, 0, 0, 0};
        int   etc[5] = '{1, 0, 0, 0, 1};
        int   eq[5]  = '{2, 2, 1, 0, 0};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            drv(1'b0, 3'd0, 1'(en[i]), 1'(ud[i]), 3'd3, 1'b1);
            sb.push_back('{q: 3'(eq[i]), wrap: 1'b0});
            #0.5;
            checks++; if (tc !== 1'(etc[i])) begin failures++; $display("FAIL sat_tc step%0d got=%0b exp=%0d", i, tc, etc[i]); end
            @(posedge clk); #0.5;
            e = sb.pop_front();
            checks++; if (q !== e.q)       begin failures++; $display("FAIL sat_q step%0d got=%0d exp=%0d", i, q, e.q); end
            checks++; if (wrap !== e.wrap) begin failures++; $display("FAIL sat_wrap step%0d got=%0b exp=%0b", i, wrap, e.wrap); end
        end
    endtask

    // M=1 wraps every edge; then a down-wrap with M=4 leaves q=3, wrap=1.
    task automatic test_back_to_back();
        int   ud[4] = '{1, 1, 1, 0};
        int   mm[4] = '{1, 1, 1, 4};
        int   eq[4] = '{0, 0, 0, 3};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, 3'd0, 1'b1, 1'(ud[i]), 3'(mm[i]), 1'b0);
            sb.push_back('{q: 3'(eq[i]), wrap: 1'b1});
            #0.5;
            checks++; if (tc !== 1'b1) begin failures++; $display("FAIL b2b_tc step%0d got=%0b exp=1", i, tc); end
            @(posedge clk); #0.5;
            e = sb.pop_front();
            checks++; if (q !== e.q)       begin failures++; $display("FAIL b2b_q step%0d got=%0d exp=%0d", i, q, e.q); end
            checks++; if (wrap !== e.wrap) begin failures++; $display("FAIL b2b_wrap step%0d got=%0b exp=%0b", i, wrap, e.wrap); end
        end
    endtask

    // Reset asserted between edges while q=3 and wrap=1.
    task automatic test_async_reset();
        exp_t e;
        drv(1'b0, 3'd0, 1'b1, 1'b1, 3'd4, 1'b0);
        #0.3;
        reset = 1'b0;
        #0.1;
        checks++; if (q !== 3'd0)    begin failures++; $display("FAIL async_q got=%0d exp=0", q); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL async_wrap got=%0b exp=0", wrap); end
        checks++; if (tc !== 1'b0)   begin failures++; $display("FAIL async_tc got=%0b exp=0", tc); end
        @(posedge clk); #0.5;
        checks++; if (q !== 3'd0) begin failures++; $display("FAIL async_hold_q got=%0d exp=0", q); end
        @(negedge clk);
        reset = 1'b1;
        sb.push_back('{q: 3'd1, wrap: 1'b0});
        @(posedge clk); #0.5;
        e = sb.pop_front();
        checks++; if (q !== e.q)       begin failures++; $display("FAIL resume_q got=%0d exp=%0d", q, e.q); end
        checks++; if (wrap !== e.wrap) begin failures++; $display("FAIL resume_wrap got=%0b exp=%0b", wrap, e.wrap); end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_load_down_sat();
        test_full_range();
        test_load_clamp();
        test_shrink_m();
        test_sat_hold();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain left=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
